// File: rtl/bin_to_bcd_seq_if.sv
// ============================================================================
// bin_to_bcd_seq_if : start/done handshake and result bus of the BCD converter
// Rev 1.0
// ============================================================================
`default_nettype none

interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic [4*DIGITS-1:0]   bcd_out;

  modport master (
    output start, bin_in,
    input  busy, done, ovf, bcd_out
  );

  modport slave (
    input  start, bin_in,
    output busy, done, ovf, bcd_out
  );
endinterface

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// ============================================================================
// bin_to_bcd_seq : sequential double-dabble binary-to-BCD converter with
//                  saturation and optional leading-zero blanking
// Rev 1.0
// ============================================================================
`default_nettype none

module bin_to_bcd_seq #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 4,
  parameter int LZB    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  function automatic logic [63:0] max_val(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_val(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [SW-1:0]     scratch;
  logic [BIN_W-1:0]  shreg;
  logic [CW-1:0]     iter;
  logic              ovf_pend;
  logic              busy_q;
  logic              done_q;
  logic              ovf_q;
  logic [SW-1:0]     bcd_q;

  logic [SW-1:0]     adj;
  logic [SW-1:0]     scratch_nx;
  logic [BIN_W-1:0]  shreg_nx;
  logic [SW-1:0]     disp;
  logic              lead;
  logic [3:0]        digit;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign adj[4*g +: 4] = (scratch[4*g +: 4] >= 4'd5) ? scratch[4*g +: 4] + 4'd3
                                                        : scratch[4*g +: 4];
  end

  // Range is checked on acceptance, so the bit shifted out of the top is always 0.
  always_comb begin
    {scratch_nx, shreg_nx} = {adj, shreg} << 1;
  end

  // Reverse digit order (MSD to the low nibble) and blank leading zeros above the units.
  always_comb begin
    disp  = '0;
    lead  = 1'b1;
    digit = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      digit = scratch[4*i +: 4];
      if (digit != 4'd0) lead = 1'b0;
      disp[4*(DIGITS-1-i) +: 4] = ((LZB != 0) && lead && (i != 0)) ? 4'hF : digit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      scratch  <= '0;
      shreg    <= '0;
      iter     <= '0;
      ovf_pend <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      bcd_q    <= {DIGITS{4'hF}};
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            shreg  <= bus.bin_in;
            busy_q <= 1'b1;
            if (64'(bus.bin_in) > MAX_VAL) begin
              ovf_pend <= 1'b1;
              scratch  <= {DIGITS{4'h9}};
              state    <= S_DONE;
            end else begin
              ovf_pend <= 1'b0;
              scratch  <= '0;
              iter     <= CW'(BIN_W);
              state    <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          scratch <= scratch_nx;
          shreg   <= shreg_nx;
          iter    <= iter - 1'b1;
          if (iter == CW'(1)) state <= S_DONE;
        end
        S_DONE: begin
          bcd_q  <= disp;
          ovf_q  <= ovf_pend;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ovf     = ovf_q;
  assign bus.bcd_out = bcd_q;

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
// ============================================================================
// tb_bin_to_bcd_seq : scoreboard bench for bin_to_bcd_seq (LZB=1 and LZB=0)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.BIN_W(32), .DIGITS(4)) bus1 ();
  bin_to_bcd_seq_if #(.BIN_W(32), .DIGITS(4)) bus0 ();

  bin_to_bcd_seq #(.BIN_W(32), .DIGITS(4), .LZB(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  bin_to_bcd_seq #(.BIN_W(32), .DIGITS(4), .LZB(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  typedef struct packed {
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  function automatic exp_t model(input logic [31:0] v, input bit lzb);
    exp_t        e;
    int unsigned x;
    int unsigned p;
    logic [3:0]  d;
    if (v > 32'd9999) begin
      e.bcd = 16'h9999;
      e.ovf = 1'b1;
      return e;
    end
    e.ovf = 1'b0;
    e.bcd = 16'h0000;
    x = v;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      d = 4'(x % 10);
      x = x / 10;
      e.bcd[4*(3-i) +: 4] = (lzb && i > 0 && v < p) ? 4'hF : d;
      p = p * 10;
    end
    return e;
  endfunction

  function automatic int lat_of(input logic [31:0] v);
    return (v > 32'd9999) ? 2 : 34;
  endfunction

  function automatic logic done_of(input bit sel);
    return sel ? bus0.done : bus1.done;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? bus0.busy : bus1.busy;
  endfunction

  task automatic drive(input bit sel, input logic st, input logic [31:0] v);
    if (sel) begin
      bus0.start  = st;
      bus0.bin_in = v;
    end else begin
      bus1.start  = st;
      bus1.bin_in = v;
    end
  endtask

  task automatic wait_done(input bit sel, input string tag, inout int c);
    while (!done_of(sel) && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (!done_of(sel)) begin
      tests++;
      failed++;
      $display("FAIL %s timeout: done never seen in %0d cycles", tag, c);
    end
  endtask

  task automatic check_result(input bit sel, input string tag, input int c, input int exp_lat);
    exp_t        e;
    logic [15:0] bcd;
    logic        ovf;
    e   = sb.pop_front();
    bcd = sel ? bus0.bcd_out : bus1.bcd_out;
    ovf = sel ? bus0.ovf : bus1.ovf;
    tests++;
    if (c !== exp_lat) begin
      failed++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", tag, c, exp_lat);
    end
    tests++;
    if (bcd !== e.bcd) begin
      failed++;
      $display("FAIL %s bcd_out: got %h, expected %h", tag, bcd, e.bcd);
    end
    tests++;
    if (ovf !== e.ovf) begin
      failed++;
      $display("FAIL %s ovf: got %b, expected %b", tag, ovf, e.ovf);
    end
    tests++;
    if (busy_of(sel) !== 1'b0) begin
      failed++;
      $display("FAIL %s busy_at_done: got %b, expected 0", tag, busy_of(sel));
    end
  endtask

  // Inputs change at negedge; bin_in is scrambled right after acceptance.
  task automatic convert(input bit sel, input logic [31:0] v, input string tag);
    int c;
    sb.push_back(model(v, !sel));
    drive(sel, 1'b1, v);
    @(negedge clk);
    drive(sel, 1'b0, $urandom);
    c = 1;
    tests++;
    if (busy_of(sel) !== 1'b1) begin
      failed++;
      $display("FAIL %s busy_after_accept: got %b, expected 1", tag, busy_of(sel));
    end
    wait_done(sel, tag, c);
    check_result(sel, tag, c, lat_of(v));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 32'd0);
    drive(1, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    tests++;
    if ({bus1.busy, bus1.done, bus1.ovf} !== 3'b000) begin
      failed++;
      $display("FAIL reset_flags: got busy/done/ovf=%b, expected 000",
               {bus1.busy, bus1.done, bus1.ovf});
    end
    tests++;
    if (bus1.bcd_out !== 16'hFFFF) begin
      failed++;
      $display("FAIL reset_bcd: got %h, expected ffff", bus1.bcd_out);
    end
    tests++;
    if (bus0.bcd_out !== 16'hFFFF || bus0.ovf !== 1'b0) begin
      failed++;
      $display("FAIL reset_lzb0: got bcd=%h ovf=%b, expected ffff 0", bus0.bcd_out, bus0.ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (bus1.busy !== 1'b0 || bus1.bcd_out !== 16'hFFFF) begin
      failed++;
      $display("FAIL idle_after_reset: got busy=%b bcd=%h, expected 0 ffff",
               bus1.busy, bus1.bcd_out);
    end
  endtask

  task automatic test_basic();
    logic [31:0] v;
    convert(0, 32'd1234, "conv_1234");
    convert(0, 32'd7,    "conv_7");
    convert(0, 32'd0,    "conv_0");
    convert(0, 32'd9999, "conv_9999");
    convert(0, 32'd42,   "conv_42");
    convert(0, 32'd1000, "conv_1000");
    for (int i = 0; i < 6; i++) begin
      v = (i % 3 == 2) ? 32'($urandom) : 32'($urandom_range(0, 9999));
      convert(0, v, "conv_random");
    end
  endtask

  task automatic test_overflow();
    convert(0, 32'd10000,      "ovf_10000");
    convert(0, 32'hFFFF_FFFF,  "ovf_max");
    convert(0, 32'd305,        "ovf_cleared");
  endtask

  task automatic test_hold();
    exp_t e;
    convert(0, 32'd805, "hold_setup");
    e = model(32'd805, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (bus1.bcd_out !== e.bcd || bus1.done !== 1'b0) begin
        failed++;
        $display("FAIL hold: got bcd=%h done=%b, expected %h 0", bus1.bcd_out, bus1.done, e.bcd);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int c;
    bit seen;
    sb.push_back(model(32'd42, 1'b1));
    drive(0, 1'b1, 32'd42);
    @(negedge clk);
    drive(0, 1'b0, 32'd0);
    c = 1;
    repeat (5) begin
      @(negedge clk);
      c++;
    end
    drive(0, 1'b1, 32'd7);
    @(negedge clk);
    c++;
    drive(0, 1'b0, 32'd0);
    wait_done(0, "busy_ignore", c);
    check_result(0, "busy_ignore", c, 34);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus1.done || bus1.busy) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      failed++;
      $display("FAIL busy_ignore_queued: got activity=%b, expected 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    sb.push_back(model(32'd9999, 1'b1));
    sb.push_back(model(32'd42, 1'b1));
    drive(0, 1'b1, 32'd9999);
    @(negedge clk);
    bus1.bin_in = 32'd42;
    c = 1;
    wait_done(0, "b2b_first", c);
    check_result(0, "b2b_first", c, 34);
    @(negedge clk);
    c = 1;
    tests++;
    if (bus1.busy !== 1'b1) begin
      failed++;
      $display("FAIL b2b_reaccept: got busy=%b, expected 1", bus1.busy);
    end
    drive(0, 1'b0, 32'd0);
    wait_done(0, "b2b_second", c);
    check_result(0, "b2b_second", c, 34);
  endtask

  task automatic test_reset_mid();
    bit seen;
    drive(0, 1'b1, 32'd1234);
    @(negedge clk);
    drive(0, 1'b0, 32'd0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus1.busy, bus1.done, bus1.ovf} !== 3'b000 || bus1.bcd_out !== 16'hFFFF) begin
      failed++;
      $display("FAIL reset_mid: got busy/done/ovf=%b bcd=%h, expected 000 ffff",
               {bus1.busy, bus1.done, bus1.ovf}, bus1.bcd_out);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus1.done) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_done: got done pulse=%b, expected 0", seen);
    end
    convert(0, 32'd56, "after_reset");
  endtask

  task automatic test_lzb0();
    convert(1, 32'd7,     "lzb0_7");
    convert(1, 32'd0,     "lzb0_0");
    convert(1, 32'd1234,  "lzb0_1234");
    convert(1, 32'd10000, "lzb0_ovf");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_hold();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_lzb0();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
